dmem_write_buffer: RTL and testbench
====================================

// Module: dmem_write_buffer
// PURPOSE
//  Posted-write buffer between the ARM datapath memory port (MemWrite/ALUResult/WriteData/ReadData)
//  and dmem. Stores retire into a FIFO in one cycle; entries drain to dmem when the port is idle.
//  Loads check the buffer and forward the youngest matching word, so buffered data is never stale.
//  Asserts stall only when a store arrives while the buffer is full and no drain occurs that cycle.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of 2, >=2
//  AW     32  address width (byte address; matching on word address [AW-1:2])
//  DW     32  data width
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   synchronous, active-high
//  cpu_we     in   1   store request (datapath MemWrite)
//  cpu_re     in   1   load request (datapath MemtoReg path)
//  cpu_addr   in   AW  ALUResult
//  cpu_wdata  in   DW  WriteData
//  cpu_rdata  out  DW  load data to datapath (combinational)
//  stall      out  1   hold PC/pipeline; store not accepted this cycle
//  mem_we     out  1   dmem write enable
//  mem_addr   out  AW  dmem address
//  mem_wdata  out  DW  dmem write data
//  mem_rdata  in   DW  dmem read data (combinational read)
//  mem_ready  in   1   dmem accepts a write this cycle
//  empty      out  1   no buffered stores (fence/halt check)
// BEHAVIOUR
//  - Reset: head=tail=count=0, all valid bits 0; outputs: stall=0, mem_we=0, empty=1,
//    mem_addr/mem_wdata=0. Reset mid-drain discards every buffered entry; no partial write issued.
//  - Port arbitration: cpu_re=1 -> mem_addr=cpu_addr, mem_we=0 (load wins, drain paused).
//    Else if !empty -> mem_addr/mem_wdata=head entry, mem_we=1. Else mem_we=0.
//  - drain = mem_we & mem_ready; on clk, head advances, count-1.
//  - push = cpu_we & !stall; on clk, entry{addr,data} written at tail, tail advances, count+1.
//  - stall = cpu_we & (count==DEPTH) & !drain. Push and drain in the same cycle: count unchanged,
//    legal even when full. cpu_we & cpu_re together is illegal (assertion in bench).
//  - Forwarding: cpu_rdata = data of youngest valid entry with addr[AW-1:2]==cpu_addr[AW-1:2],
//    else mem_rdata. Entry being drained this cycle still counts as valid for forwarding.
//  - Latency: store accept 0 cycles (same edge); earliest dmem write is the next cycle if port idle.
//  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits; no overflow/underflow possible.
//  - Order: dmem sees writes in program order (or coalesced, below).
// CONFIGURATION
//  WBUF_COALESCE_EN defined: a store whose word address matches the youngest valid entry, where that
//    entry is not the head being drained this cycle, overwrites that entry's data; no allocation,
//    count unchanged, never stalls even when full.
//  Undefined: every accepted store allocates a new entry; duplicate addresses drain separately.
// STRUCTURE
//  - Shared package dmem_wbuf_pkg: entry struct {valid, addr, data}, DEPTH default, PTR_W function.
//  - One sub-module: wbuf_fifo (storage, head/tail/count, push/pop, full/empty). Top holds
//    arbitration, stall, forwarding compare and the coalesce logic.
// TESTING
//  1 Reset, then idle: empty=1, mem_we=0, stall=0; cpu_re addr 0x40 returns mem_rdata unchanged.
//  2 Store 0x10<-0xAAAA_0001, mem_ready=1: next cycle mem_we=1, addr 0x10, data 0xAAAA_0001; then empty=1.
//  3 mem_ready=0, 5 stores (DEPTH=4): stores 1-4 accepted, 5th sees stall=1 until mem_ready=1,
//    then accepted on the drain cycle; dmem receives all 5 in order.
//  4 Stores 0x20<-1 then 0x20<-2 buffered, load 0x22 -> cpu_rdata=2 (youngest, word match);
//    load 0x24 -> mem_rdata.
//  5 Load during pending drain: cpu_re=1 forces mem_we=0; head unchanged; drain resumes next cycle.
//  6 reset asserted with 3 entries pending: next cycle empty=1, mem_we=0, no further writes;
//    WBUF_COALESCE_EN: two stores to 0x30 produce one dmem write of the last data.

Source files
------------

// File: rtl/dmem_wbuf_pkg.sv
// Shared types and helpers for the dmem posted-write buffer.
package dmem_wbuf_pkg;

  localparam int WBUF_DEPTH = 4;
  localparam int WBUF_AW    = 32;
  localparam int WBUF_DW    = 32;

  typedef struct packed {
    logic               valid;
    logic [WBUF_AW-1:0] addr;
    logic [WBUF_DW-1:0] data;
  } wbuf_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Circular store buffer: entry storage, head/tail/count, push/pop and an in-place
// data update of the youngest entry. Exposes every entry for load forwarding.
module wbuf_fifo
  import dmem_wbuf_pkg::*;
#(
  parameter  int DEPTH = WBUF_DEPTH,
  parameter  int AW    = WBUF_AW,
  parameter  int DW    = WBUF_DW,
  localparam int PW    = ptr_w(DEPTH),
  localparam int WA    = AW - 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [AW-1:0]       push_addr_i,
  input  logic [DW-1:0]       push_data_i,
  input  logic                upd_i,
  input  logic [DW-1:0]       upd_data_i,
  output logic [AW-1:0]       head_addr_o,
  output logic [DW-1:0]       head_data_o,
  output logic [PW-1:0]       tail_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH-1:0]    valid_o,
  output logic [DEPTH*WA-1:0] waddr_o,
  output logic [DEPTH*DW-1:0] data_o
);

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (pop_i) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (upd_i) begin
      data_d[tail_q - PW'(1)] = upd_data_i;
    end
    // When full, push and pop share a slot; the push must win the valid bit.
    if (push_i) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = push_addr_i;
      data_d[tail_q]  = push_data_i;
      tail_d          = tail_q + PW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];
  assign tail_o      = tail_q;
  assign full_o      = (count_q == (PW+1)'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign valid_o     = valid_q;

  always_comb begin
    waddr_o = '0;
    data_o  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      waddr_o[i*WA +: WA] = addr_q[i][AW-1:2];
      data_o[i*DW +: DW]  = data_q[i];
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the datapath memory port and dmem: arbitration, stall,
// load forwarding. Optional store coalescing is enabled by defining WBUF_COALESCE_EN.
module dmem_write_buffer
  import dmem_wbuf_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH,
  parameter int AW    = WBUF_AW,
  parameter int DW    = WBUF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          stall,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int WA = AW - 2;

  logic                push, drain, coal_hit;
  logic                fifo_full, fifo_empty;
  logic [AW-1:0]       head_addr;
  logic [DW-1:0]       head_data;
  logic [PW-1:0]       tail;
  logic [DEPTH-1:0]    ent_valid;
  logic [DEPTH*WA-1:0] ent_waddr;
  logic [DEPTH*DW-1:0] ent_data;

  wbuf_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (drain),
    .push_addr_i (cpu_addr),
    .push_data_i (cpu_wdata),
    .upd_i       (coal_hit),
    .upd_data_i  (cpu_wdata),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .tail_o      (tail),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .valid_o     (ent_valid),
    .waddr_o     (ent_waddr),
    .data_o      (ent_data)
  );

`ifdef WBUF_COALESCE_EN
  logic [PW-1:0] young;
  assign young = tail - PW'(1);
  // A single valid entry is both youngest and head; it cannot be rewritten while draining.
  assign coal_hit = cpu_we & ~reset & ~fifo_empty
                  & (ent_waddr[young*WA +: WA] == cpu_addr[AW-1:2])
                  & ~($onehot(ent_valid) & drain);
`else
  assign coal_hit = 1'b0;
`endif

  // Reset masks the write strobe so a flush never issues a partial dmem write.
  assign mem_we    = ~reset & ~cpu_re & ~fifo_empty;
  assign drain     = mem_we & mem_ready;
  assign stall     = ~reset & cpu_we & fifo_full & ~drain & ~coal_hit;
  assign push      = cpu_we & ~stall & ~coal_hit;
  assign mem_addr  = cpu_re ? cpu_addr : (fifo_empty ? '0 : head_addr);
  assign mem_wdata = fifo_empty ? '0 : head_data;
  assign empty     = fifo_empty;

  // Walk from oldest to youngest so the youngest word match is the last assignment.
  always_comb begin
    logic [PW-1:0] idx;
    logic          hit;
    logic [DW-1:0] fwd;
    hit = 1'b0;
    fwd = '0;
    idx = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      idx = tail - PW'(1) - PW'(k);
      if (ent_valid[idx] && (ent_waddr[idx*WA +: WA] == cpu_addr[AW-1:2])) begin
        hit = 1'b1;
        fwd = ent_data[idx*DW +: DW];
      end
    end
    cpu_rdata = hit ? fwd : mem_rdata;
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Self-checking bench for dmem_write_buffer against a queue-based model of the buffer.
module tb_dmem_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_we = 1'b0, cpu_re = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          stall, mem_we, empty;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  dmem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .empty     (empty)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          dut_writes = 0;
  logic [31:0] last_wd;
  logic        obs_we, obs_stall, obs_empty;
  logic [31:0] obs_addr, obs_wd, obs_rdata, obs_mr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_fwd(input logic [31:0] a, input logic [31:0] mr);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a[31:2] == a[31:2]) return q[i].d;
    return mr;
  endfunction

  task automatic step(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    logic        e_we, e_drain, e_stall, coal;
    logic [31:0] e_addr;
    @(negedge clk);
    assert (!(we && re)) else $fatal(1, "FAIL stimulus we_and_re both set");
    cpu_we    = we;
    cpu_re    = re;
    cpu_addr  = a;
    cpu_wdata = d;
    mem_ready = rdy;
    mem_rdata = $urandom();
    #1;
    e_we    = !re && (q.size() > 0);
    e_drain = e_we && rdy;
    coal    = 1'b0;
`ifdef WBUF_COALESCE_EN
    coal = we && (q.size() > 0) && (q[q.size()-1].a[31:2] == a[31:2])
              && !(q.size() == 1 && e_drain);
`endif
    e_stall = we && !coal && (q.size() == DEPTH) && !e_drain;
    e_addr  = re ? a : ((q.size() > 0) ? q[0].a : 32'h0);
    check("stall", stall, e_stall);
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    check("empty", empty, q.size() == 0);
    if (e_we) check("mem_wdata", mem_wdata, q[0].d);
    if (re) check("cpu_rdata", cpu_rdata, model_fwd(a, mem_rdata));
    obs_we = mem_we; obs_stall = stall; obs_empty = empty;
    obs_addr = mem_addr; obs_wd = mem_wdata; obs_rdata = cpu_rdata; obs_mr = mem_rdata;
    if (mem_we && mem_ready) begin
      dut_writes++;
      last_wd = mem_wdata;
    end
    if (coal) q[q.size()-1].d = d;
    if (e_drain) void'(q.pop_front());
    if (we && !e_stall && !coal) q.push_back('{a: a, d: d});
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; mem_ready = 1'b1;
    #1;
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_stall", stall, 1'b0);
    if (mem_we && mem_ready) dut_writes++;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    #1;
    check("post_rst_empty", empty, 1'b1);
    check("post_rst_mem_we", mem_we, 1'b0);
    check("post_rst_stall", stall, 1'b0);
    check("post_rst_mem_addr", mem_addr, 32'h0);
    check("post_rst_mem_wdata", mem_wdata, 32'h0);
  endtask

  initial begin
    int w0;
    // 1: reset, idle load passes mem_rdata through
    do_reset();
    step(1'b0, 1'b1, 32'h40, 32'h0, 1'b1);
    check("t1_rdata", obs_rdata, obs_mr);
    check("t1_we", obs_we, 1'b0);

    // 2: single store drains the following cycle
    do_reset();
    step(1'b1, 1'b0, 32'h10, 32'hAAAA_0001, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("t2_we", obs_we, 1'b1);
    check("t2_addr", obs_addr, 32'h10);
    check("t2_wdata", obs_wd, 32'hAAAA_0001);
    idle(1, 1'b1);
    check("t2_empty", obs_empty, 1'b1);

    // 3: full buffer stalls the fifth store until a drain frees a slot
    do_reset();
    w0 = dut_writes;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h100 + 32'(i*4), 32'h300 + 32'(i), 1'b0);
    step(1'b1, 1'b0, 32'h110, 32'h304, 1'b0);
    check("t3_stall_full", obs_stall, 1'b1);
    step(1'b1, 1'b0, 32'h110, 32'h304, 1'b1);
    check("t3_stall_drain", obs_stall, 1'b0);
    check("t3_first_addr", obs_addr, 32'h100);
    idle(6, 1'b1);
    check("t3_writes", 32'(dut_writes - w0), 32'd5);
    check("t3_last", last_wd, 32'h304);

    // 4: forwarding picks the youngest word match
    do_reset();
    step(1'b1, 1'b0, 32'h20, 32'h1, 1'b0);
    step(1'b1, 1'b0, 32'h20, 32'h2, 1'b0);
    step(1'b0, 1'b1, 32'h22, 32'h0, 1'b0);
    check("t4_fwd", obs_rdata, 32'h2);
    step(1'b0, 1'b1, 32'h24, 32'h0, 1'b0);
    check("t4_miss", obs_rdata, obs_mr);

    // 5: a load pauses the drain; it resumes next cycle
    w0 = dut_writes;
    step(1'b0, 1'b1, 32'h40, 32'h0, 1'b1);
    check("t5_paused_we", obs_we, 1'b0);
    check("t5_not_empty", obs_empty, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("t5_resume_we", obs_we, 1'b1);
    check("t5_resume_addr", obs_addr, 32'h20);
    check("t5_write", 32'(dut_writes - w0), 32'd1);

    // 6: reset with three pending entries discards them
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h50 + 32'(i*4), 32'h70 + 32'(i), 1'b0);
    w0 = dut_writes;
    do_reset();
    idle(3, 1'b1);
    check("t6_no_writes", 32'(dut_writes - w0), 32'd0);
    check("t6_we", obs_we, 1'b0);

    // 7: same-address stores
    do_reset();
    w0 = dut_writes;
    step(1'b1, 1'b0, 32'h30, 32'h11, 1'b0);
    step(1'b1, 1'b0, 32'h30, 32'h22, 1'b0);
    idle(4, 1'b1);
`ifdef WBUF_COALESCE_EN
    check("t7_coal_writes", 32'(dut_writes - w0), 32'd1);
`else
    check("t7_dup_writes", 32'(dut_writes - w0), 32'd2);
`endif
    check("t7_last", last_wd, 32'h22);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic we, re, rdy;
      logic [31:0] a;
      if ($urandom_range(0, 149) == 0) do_reset();
      we  = ($urandom_range(0, 2) == 0);
      re  = !we && ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      a   = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      step(we, re, a, $urandom(), rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
